// File: rtl/gdiv_pkg.sv
// Shared definitions for the Goldschmidt divide/sqrt sequencing controller.
//   gdiv_state_t : controller state encoding
//   MSEL_*       : multiplier operand-select encoding seen by the datapath
//   OP_*         : operation codes carried on op / op_q
package gdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MUL_N,
        S_MUL_D,
        S_MUL_D2,
        S_REM,
        S_ROUND,
        S_DONE
    } gdiv_state_t;

    localparam logic [1:0] MSEL_NONE = 2'd0;
    localparam logic [1:0] MSEL_NK   = 2'd1;
    localparam logic [1:0] MSEL_DK   = 2'd2;
    localparam logic [1:0] MSEL_QD   = 2'd3;
    // The datapath tells Q*Q apart from Q*D by looking at op_q.
    localparam logic [1:0] MSEL_QQ   = MSEL_QD;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_SQRT = 1'b1;

    // States that occupy the shared multiplier for MUL_LAT cycles.
    function automatic logic is_mul_state(input gdiv_state_t s);
        return (s == S_MUL_N) || (s == S_MUL_D) || (s == S_MUL_D2) || (s == S_REM);
    endfunction

endpackage

// File: rtl/gdiv_ctrl_if.sv
// Bundle of request/status and datapath-control signals of gdiv_ctrl.
//   master : requester side (drives start/op/rm, observes everything else)
//   slave  : controller side (gdiv_ctrl)
// ITER sets the width of the iteration index.
interface gdiv_ctrl_if #(
    parameter int ITER = 4
);
    localparam int IW = $clog2(ITER + 1);

    logic          start;
    logic          op;
    logic [1:0]    rm;
    logic          ready;
    logic          busy;
    logic          done;
    logic          op_q;
    logic [1:0]    rm_q;
    logic          ld_init;
    logic [1:0]    mul_sel;
    logic          en_n;
    logic          en_d;
    logic          en_k;
    logic          en_rem;
    logic          round_en;
    logic [IW-1:0] iter;

    modport master (
        output start, op, rm,
        input  ready, busy, done, op_q, rm_q, ld_init, mul_sel,
               en_n, en_d, en_k, en_rem, round_en, iter
    );

    modport slave (
        input  start, op, rm,
        output ready, busy, done, op_q, rm_q, ld_init, mul_sel,
               en_n, en_d, en_k, en_rem, round_en, iter
    );

endinterface

// File: rtl/gdiv_ctrl_lat_counter.sv
// Multiplier latency counter shared by all multiply states.
//   clk, reset : clock, async active-high reset
//   clr        : restart from zero on the next edge
//   last       : current cycle is the final one of a MUL_LAT-cycle window
// The controller holds clr high outside multiply states and on the last
// cycle of each one, so the count is zero on every state entry.
module lat_counter #(
    parameter int MUL_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic last
);
    localparam int            CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CNT_LAST);

endmodule

// File: rtl/gdiv_ctrl.sv
// Sequencing controller for the shared-multiplier Goldschmidt divide/sqrt
// datapath. Pure control: latches op/rm on accept, then walks the datapath
// through INIT, ITER rounds of N/D(/D2) multiplies, a remainder multiply and
// rounding, and pulses done for one cycle.
//   clk, reset : clock, async active-high reset
//   bus        : request/status and datapath controls (gdiv_ctrl_if.slave)
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | ready, waiting for start
// S_INIT   | datapath loads N, D and seed K
// S_MUL_N  | N <= N*K
// S_MUL_D  | D <= D*K (divide: also K from new D)
// S_MUL_D2 | sqrt only: second D*K, then K from new D
// S_REM    | remainder multiply Q*D or Q*Q
// S_ROUND  | rounding using rem and rm_q
// S_DONE   | one-cycle done pulse
module gdiv_ctrl
    import gdiv_pkg::*;
#(
    parameter int ITER    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    gdiv_ctrl_if.slave   bus
);
    localparam int            IW        = $clog2(ITER + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

    gdiv_state_t   state_q, state_d;
    logic          op_q;
    logic [1:0]    rm_q;
    logic [IW-1:0] iter_q;
    logic          accept;
    logic          iter_inc;
    logic          lat_last;
    logic          lat_clr;

    lat_counter #(.MUL_LAT(MUL_LAT)) u_lat (
        .clk   (clk),
        .reset (reset),
        .clr   (lat_clr),
        .last  (lat_last)
    );

    // Every multiply state leaves on its last cycle, so clearing then
    // guarantees a zero count on entry to the next one.
    assign lat_clr = !is_mul_state(state_q) || lat_last;
    assign accept  = (state_q == S_IDLE) && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            rm_q    <= 2'b00;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= bus.op;
                rm_q   <= bus.rm;
                iter_q <= '0;
            end else if (iter_inc) begin
                iter_q <= iter_q + IW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        iter_inc     = 1'b0;
        bus.ld_init  = 1'b0;
        bus.mul_sel  = MSEL_NONE;
        bus.en_n     = 1'b0;
        bus.en_d     = 1'b0;
        bus.en_k     = 1'b0;
        bus.en_rem   = 1'b0;
        bus.round_en = 1'b0;
        bus.done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_INIT;
            end
            S_INIT: begin
                bus.ld_init = 1'b1;
                state_d     = S_MUL_N;
            end
            S_MUL_N: begin
                bus.mul_sel = MSEL_NK;
                if (lat_last) begin
                    bus.en_n = 1'b1;
                    state_d  = S_MUL_D;
                end
            end
            S_MUL_D: begin
                bus.mul_sel = MSEL_DK;
                if (lat_last) begin
                    bus.en_d = 1'b1;
                    if (op_q == OP_SQRT) begin
                        state_d = S_MUL_D2;
                    end else begin
                        bus.en_k = 1'b1;
                        if (iter_q < ITER_LAST) begin
                            state_d  = S_MUL_N;
                            iter_inc = 1'b1;
                        end else begin
                            state_d = S_REM;
                        end
                    end
                end
            end
            S_MUL_D2: begin
                bus.mul_sel = MSEL_DK;
                if (lat_last) begin
                    bus.en_d = 1'b1;
                    bus.en_k = 1'b1;
                    if (iter_q < ITER_LAST) begin
                        state_d  = S_MUL_N;
                        iter_inc = 1'b1;
                    end else begin
                        state_d = S_REM;
                    end
                end
            end
            S_REM: begin
                bus.mul_sel = (op_q == OP_SQRT) ? MSEL_QQ : MSEL_QD;
                if (lat_last) begin
                    bus.en_rem = 1'b1;
                    state_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                bus.round_en = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.op_q  = op_q;
    assign bus.rm_q  = rm_q;
    assign bus.iter  = iter_q;

endmodule

// File: tb/tb_gdiv_ctrl.sv
// Directed bench for gdiv_ctrl. Three instances cover ITER=4/MUL_LAT=1,
// ITER=4/MUL_LAT=2 and ITER=1/MUL_LAT=1. Expected per-cycle behaviour is
// written as a string of cycle codes, one character per cycle after the
// accept edge.
module tb_gdiv_ctrl;
    import gdiv_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic       op = 1'b0;
    logic [1:0] rm = 2'b00;

    int n_checks = 0;
    int n_err    = 0;
    int cnt_en_d = 0;
    int cnt_en_k = 0;
    int cnt_done = 0;

    always #5 clk = ~clk;

    gdiv_ctrl_if #(.ITER(4)) if0 ();
    gdiv_ctrl_if #(.ITER(4)) if1 ();
    gdiv_ctrl_if #(.ITER(1)) if2 ();

    assign if0.start = start_v[0];
    assign if0.op    = op;
    assign if0.rm    = rm;
    assign if1.start = start_v[1];
    assign if1.op    = op;
    assign if1.rm    = rm;
    assign if2.start = start_v[2];
    assign if2.op    = op;
    assign if2.rm    = rm;

    gdiv_ctrl #(.ITER(4), .MUL_LAT(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    gdiv_ctrl #(.ITER(4), .MUL_LAT(2)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    gdiv_ctrl #(.ITER(1), .MUL_LAT(1)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    // [16:14] iter, [13] op_q, [12:11] rm_q,
    // [10] busy, [9:8] mul_sel, [7:0] {ld_init,en_n,en_d,en_k,en_rem,round_en,done,ready}
    logic [16:0] mon0, mon1, mon2;
    assign mon0 = {if0.iter, if0.op_q, if0.rm_q, if0.busy, if0.mul_sel, if0.ld_init, if0.en_n,
                   if0.en_d, if0.en_k, if0.en_rem, if0.round_en, if0.done, if0.ready};
    assign mon1 = {if1.iter, if1.op_q, if1.rm_q, if1.busy, if1.mul_sel, if1.ld_init, if1.en_n,
                   if1.en_d, if1.en_k, if1.en_rem, if1.round_en, if1.done, if1.ready};
    assign mon2 = {2'b00, if2.iter, if2.op_q, if2.rm_q, if2.busy, if2.mul_sel, if2.ld_init, if2.en_n,
                   if2.en_d, if2.en_k, if2.en_rem, if2.round_en, if2.done, if2.ready};

    always @(negedge clk) begin
        if (if0.en_d) cnt_en_d++;
        if (if0.en_k) cnt_en_k++;
        if (if0.done) cnt_done++;
    end

    // Cycle codes: Y idle, I init, n/N MUL_N (N = last cycle), d/D divide MUL_D,
    // S sqrt MUL_D last, K MUL_D2 last, r/R REM, O round, F done.
    function automatic logic [10:0] code_vec(input byte ch);
        logic       b;
        logic [1:0] s;
        logic [7:0] f;
        b = 1'b1;
        s = 2'd0;
        f = 8'h00;
        case (ch)
            "Y": begin b = 1'b0; f = 8'b0000_0001; end
            "I": f = 8'b1000_0000;
            "n": s = 2'd1;
            "N": begin s = 2'd1; f = 8'b0100_0000; end
            "d": s = 2'd2;
            "D": begin s = 2'd2; f = 8'b0011_0000; end
            "S": begin s = 2'd2; f = 8'b0010_0000; end
            "K": begin s = 2'd2; f = 8'b0011_0000; end
            "r": s = 2'd3;
            "R": begin s = 2'd3; f = 8'b0000_1000; end
            "O": f = 8'b0000_0100;
            "F": f = 8'b0000_0010;
            default: f = 8'hFF;
        endcase
        return {b, s, f};
    endfunction

    function automatic logic [16:0] mon_of(input int which);
        case (which)
            0: return mon0;
            1: return mon1;
            default: return mon2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Accept one operation on instance 'which' at the next edge, then check
    // every following cycle against the code string.
    task automatic run_seq(input int which, input string tag, input string pat,
                           input logic op_v, input logic [1:0] rm_v, input bit iter0);
        logic [16:0] m;
        start_v[which] = 1'b1;
        op = op_v;
        rm = rm_v;
        @(posedge clk);
        for (int c = 0; c < pat.len(); c++) begin
            @(negedge clk);
            m = mon_of(which);
            chk($sformatf("%s_c%0d_ctrl", tag, c + 1), 32'(m[10:0]), 32'(code_vec(pat[c])));
            chk($sformatf("%s_c%0d_opq_rmq", tag, c + 1), 32'(m[13:11]), 32'({op_v, rm_v}));
            if (iter0) chk($sformatf("%s_c%0d_iter", tag, c + 1), 32'(m[16:14]), 32'd0);
            if (c == 0) begin
                start_v[which] = 1'b0;
                op = ~op_v;
                rm = ~rm_v;
            end
        end
    endtask

    initial begin
        string p5a;
        string p5b;
        logic [16:0] m;

        // reset values, during and after reset
        #2;
        chk("rst_during_0", 32'(mon0), 32'(code_vec("Y")));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_after_0", 32'(mon0), 32'(code_vec("Y")));
        chk("rst_after_1", 32'(mon1), 32'(code_vec("Y")));
        chk("rst_after_2", 32'(mon2), 32'(code_vec("Y")));

        // divide, ITER=4, MUL_LAT=1
        run_seq(0, "div41", "INDNDNDNDROFY", OP_DIV, 2'b01, 1'b0);

        // sqrt, ITER=4, MUL_LAT=1
        cnt_en_d = 0;
        cnt_en_k = 0;
        run_seq(0, "sqrt41", "INSKNSKNSKNSKROFY", OP_SQRT, 2'b10, 1'b0);
        chk("sqrt41_en_d_count", 32'(cnt_en_d), 32'd8);
        chk("sqrt41_en_k_count", 32'(cnt_en_k), 32'd4);

        // divide, MUL_LAT=2
        run_seq(1, "div42", "InNdDnNdDnNdDnNdDrROFY", OP_DIV, 2'b11, 1'b0);

        // divide, ITER=1
        run_seq(2, "div11", "INDROFY", OP_DIV, 2'b00, 1'b1);

        // start held high, op toggling, rm changed after accept
        p5a = "INDNDNDNDROFY";
        p5b = "NSKNSKNSKNSKROFY";
        start_v[0] = 1'b1;
        op = 1'b0;
        rm = 2'b11;
        @(posedge clk);
        for (int c = 0; c < p5a.len(); c++) begin
            @(negedge clk);
            chk($sformatf("hold_a_c%0d_ctrl", c + 1), 32'(mon0[10:0]), 32'(code_vec(p5a[c])));
            chk($sformatf("hold_a_c%0d_opq_rmq", c + 1), 32'(mon0[13:11]), 32'({1'b0, 2'b11}));
            op = ~op;
            rm = 2'b00;
        end
        // op is now 1 after 13 toggles: the IDLE-cycle accept starts a sqrt
        @(negedge clk);
        chk("hold_b_init_ctrl", 32'(mon0[10:0]), 32'(code_vec("I")));
        chk("hold_b_opq_rmq", 32'(mon0[13:11]), 32'({1'b1, 2'b00}));
        start_v[0] = 1'b0;
        for (int c = 0; c < p5b.len(); c++) begin
            @(negedge clk);
            chk($sformatf("hold_b_c%0d_ctrl", c + 2), 32'(mon0[10:0]), 32'(code_vec(p5b[c])));
        end
        @(negedge clk);
        chk("hold_idle_stays", 32'(mon0[10:0]), 32'(code_vec("Y")));

        // reset in the middle of a divide's MUL_D
        cnt_done = 0;
        start_v[0] = 1'b1;
        op = OP_DIV;
        rm = 2'b10;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_mul_d", 32'(mon0[10:0]), 32'(code_vec("D")));
        reset = 1'b1;
        #1;
        m = mon0;
        chk("midrst_same_cycle_ctrl", 32'(m[10:0]), 32'(code_vec("Y")));
        chk("midrst_same_cycle_regs", 32'(m[16:11]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("midrst_no_done", 32'(cnt_done), 32'd0);
        chk("midrst_idle", 32'(mon0[10:0]), 32'(code_vec("Y")));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
